// File: rtl/lcd_bcd_counter_n.sv
// Multi-digit BCD up/down counter driving a static LCD.
// Segments are AC-driven against a square-wave common electrode.
module lcd_bcd_counter_n #(
  parameter int DIGITS    = 2,
  parameter int CNT_LOG2  = 11,
  parameter int DISP_LOG2 = 5
) (
  input  logic                  osc_sclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic                  lcdcom,
  output logic [7*DIGITS-1:0]   lcdseg,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry
);

  logic [CNT_LOG2-1:0] presc;
  logic                strobe;
  logic                step;
  logic                rip;
  logic                wrap;
  logic [3:0]          dig;
  logic [4*DIGITS-1:0] cnt_nxt;
  logic [4*DIGITS-1:0] load_bcd;
  logic                zero_hi;
  logic [6:0]          pat;

  assign strobe = &presc;
  assign step   = strobe & en & ~load;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0111001;
    endcase
  endfunction

  // Ripple carry/borrow; rip left set means every digit rolled over.
  always_comb begin
    rip     = 1'b1;
    dig     = '0;
    cnt_nxt = count;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (rip) begin
        if (up) begin
          rip = (dig == 4'd9);
          cnt_nxt[4*i +: 4] = rip ? 4'd0 : dig + 4'd1;
        end else begin
          rip = (dig == 4'd0);
          cnt_nxt[4*i +: 4] = rip ? 4'd9 : dig - 4'd1;
        end
      end
    end
    wrap = rip;
  end

  always_comb begin
    load_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] <= 4'd9)
        load_bcd[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Walk from the top digit so zero_hi covers this digit and all above.
  always_comb begin
    zero_hi = 1'b1;
    pat     = '0;
    lcdseg  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi & (count[4*i +: 4] == 4'd0);
      if (i != 0 && blank_lz && zero_hi)
        pat = 7'b0000000;
      else
        pat = seg7(count[4*i +: 4]);
      lcdseg[7*i +: 7] = pat ^ {7{lcdcom}};
    end
  end

  always_ff @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      lcdcom <= 1'b0;
      count  <= '0;
      tick   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      presc  <= presc + 1'b1;
      lcdcom <= presc[DISP_LOG2];
      tick   <= step;
      carry  <= step & wrap;
      if (load)
        count <= load_bcd;
      else if (step)
        count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_bcd_counter_n.sv
// Bench for lcd_bcd_counter_n: integer-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_lcd_bcd_counter_n;

  localparam int DIGITS    = 2;
  localparam int CNT_LOG2  = 4;
  localparam int DISP_LOG2 = 1;
  localparam int PMAX      = 1 << CNT_LOG2;
  localparam int CMAX      = 100;

  logic        osc_sclk = 1'b0;
  logic        rst      = 1'b1;
  logic        en       = 1'b1;
  logic        up       = 1'b1;
  logic        load     = 1'b0;
  logic [7:0]  load_val = '0;
  logic        blank_lz = 1'b0;
  logic        lcdcom;
  logic [13:0] lcdseg;
  logic [7:0]  count;
  logic        tick;
  logic        carry;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_bcd_counter_n #(
    .DIGITS(DIGITS), .CNT_LOG2(CNT_LOG2), .DISP_LOG2(DISP_LOG2)
  ) dut (
    .osc_sclk(osc_sclk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .lcdcom(lcdcom),
    .lcdseg(lcdseg), .count(count), .tick(tick), .carry(carry)
  );

  always #5 osc_sclk = ~osc_sclk;

  logic [6:0] segtab [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  int m_presc;
  int m_cnt;
  bit m_com;
  bit m_tick;
  bit m_carry;

  function automatic int bcd_to_int(input logic [7:0] v);
    int hi;
    int lo;
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] m_count_bcd();
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(m_cnt / 10);
    lo = 4'(m_cnt % 10);
    return {hi, lo};
  endfunction

  function automatic logic [13:0] m_seg();
    logic [6:0] p1;
    logic [6:0] p0;
    p0 = segtab[m_cnt % 10];
    p1 = (blank_lz && (m_cnt / 10) == 0) ? 7'b0 : segtab[m_cnt / 10];
    return {p1 ^ {7{m_com}}, p0 ^ {7{m_com}}};
  endfunction

  always @(posedge osc_sclk or posedge rst) begin
    if (rst) begin
      m_presc = 0; m_cnt = 0; m_com = 0; m_tick = 0; m_carry = 0;
    end else begin
      m_tick  = 0;
      m_carry = 0;
      m_com   = ((m_presc >> DISP_LOG2) & 1) == 1;
      if (load) begin
        m_cnt = bcd_to_int(load_val);
      end else if (m_presc == PMAX - 1 && en) begin
        m_tick = 1;
        if (up) begin
          m_carry = (m_cnt == CMAX - 1);
          m_cnt   = (m_cnt + 1) % CMAX;
        end else begin
          m_carry = (m_cnt == 0);
          m_cnt   = (m_cnt + CMAX - 1) % CMAX;
        end
      end
      m_presc = (m_presc + 1) % PMAX;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge osc_sclk) begin
    check("m_count", 32'(count), 32'(m_count_bcd()));
    check("m_lcdcom", 32'(lcdcom), 32'(m_com));
    check("m_lcdseg", 32'(lcdseg), 32'(m_seg()));
    check("m_tick", 32'(tick), 32'(m_tick));
    check("m_carry", 32'(carry), 32'(m_carry));
  end

  task automatic edge1();
    @(posedge osc_sclk);
    #1;
  endtask

  task automatic wait_tick(input string name, input int maxc);
    bit got;
    got = 0;
    for (int i = 0; i < maxc; i++) begin
      edge1();
      if (tick) begin
        got = 1;
        break;
      end
    end
    check({name, "_timeout"}, 32'(got), 32'd1);
  endtask

  initial begin
    repeat (3) edge1();
    check("rst_count", 32'(count), 32'h00);
    check("rst_com", 32'(lcdcom), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_seg", 32'(lcdseg), 32'(14'b0111111_0111111));
    blank_lz = 1'b1;
    #1;
    check("rst_seg_blank", 32'(lcdseg), 32'(14'b0000000_0111111));

    @(negedge osc_sclk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      edge1();
      if (k == 3) check("com_e3", 32'(lcdcom), 32'd1);
      if (k == 5) check("com_e5", 32'(lcdcom), 32'd0);
      if (k == 15) begin
        check("pre_step_count", 32'(count), 32'h00);
        check("pre_step_tick", 32'(tick), 32'd0);
      end
    end
    check("first_step_count", 32'(count), 32'h01);
    check("first_step_tick", 32'(tick), 32'd1);
    check("first_step_carry", 32'(carry), 32'd0);
    edge1();
    check("tick_one_cycle", 32'(tick), 32'd0);

    load = 1'b1; load_val = 8'h98;
    edge1();
    load = 1'b0;
    check("load98", 32'(count), 32'h98);
    wait_tick("up99", 20);
    check("up99_count", 32'(count), 32'h99);
    check("up99_carry", 32'(carry), 32'd0);
    wait_tick("up00", 20);
    check("up00_count", 32'(count), 32'h00);
    check("up00_carry", 32'(carry), 32'd1);
    edge1();
    check("up00_carry_end", 32'(carry), 32'd0);

    up = 1'b0;
    load = 1'b1; load_val = 8'h00;
    edge1();
    load = 1'b0;
    wait_tick("dn99", 20);
    check("dn99_count", 32'(count), 32'h99);
    check("dn99_carry", 32'(carry), 32'd1);
    wait_tick("dn98", 20);
    check("dn98_count", 32'(count), 32'h98);
    check("dn98_carry", 32'(carry), 32'd0);

    repeat (15) edge1();
    load = 1'b1; load_val = 8'h3C;
    edge1();
    load = 1'b0;
    check("ldstrobe_count", 32'(count), 32'h30);
    check("ldstrobe_tick", 32'(tick), 32'd0);
    repeat (15) edge1();
    check("presc_kept_hold", 32'(count), 32'h30);
    edge1();
    check("presc_kept_step", 32'(count), 32'h29);
    check("presc_kept_tick", 32'(tick), 32'd1);

    en = 1'b0; up = 1'b1;
    load = 1'b1; load_val = 8'h05;
    edge1();
    load = 1'b0;
    blank_lz = 1'b1;
    for (int k = 0; k < 2; k++) begin
      edge1();
      check("blank_d1", 32'(lcdseg[13:7]), 32'({7{m_com}}));
      check("blank_d0", 32'(lcdseg[6:0]), 32'(7'b1101101 ^ {7{m_com}}));
    end
    blank_lz = 1'b0;
    #1;
    check("noblank_d1", 32'(lcdseg[13:7]), 32'(7'b0111111 ^ {7{m_com}}));

    for (int k = 0; k < 3 * PMAX; k++) begin
      edge1();
      check("en0_count", 32'(count), 32'h05);
      check("en0_tick", 32'(tick), 32'd0);
    end

    en = 1'b1;
    wait_tick("pre_rst", 20);
    check("pre_rst_count", 32'(count), 32'h06);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'h00);
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    check("midrst_com", 32'(lcdcom), 32'd0);
    check("midrst_seg", 32'(lcdseg), 32'(14'b0111111_0111111));
    repeat (2) edge1();
    @(negedge osc_sclk);
    rst = 1'b0;
    repeat (20) edge1();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
